// File: rtl/clint_mp.sv
// Multi-hart core-local interruptor: per-hart msip and mtimecmp registers,
// one shared 64-bit mtime driven by a programmable prescaler, and a registered
// one-wait-state strobe/ack bus port.
module clint_mp #(
    parameter int          NUM_HARTS    = 2,
    parameter int          DIV          = 1,
    parameter logic [63:0] MTIMECMP_RST = 64'h7fff_ffff_ffff_ffff
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [15:0]          i_addr,
    input  logic [3:0]           i_we,
    input  logic [31:0]          i_dat_w,
    output logic [31:0]          o_dat_r,
    input  logic                 i_stb,
    output logic                 o_ack,
    output logic [NUM_HARTS-1:0] o_timer_int,
    output logic [NUM_HARTS-1:0] o_software_int
);

    localparam logic [3:0]  HART_LIMIT = 4'(NUM_HARTS);
    localparam logic [15:0] PCNT_LAST  = 16'(DIV - 1);

    logic        ack_reg;
    logic [31:0] dat_r_reg;
    logic        accept;
    logic        is_write;
    logic        sel_msip;
    logic        sel_cmp;
    logic        sel_mtime;
    logic        hi_word;
    logic [2:0]  msip_hart;
    logic [2:0]  cmp_hart;
    logic        unused_addr_bits;

    logic        msip_reg      [NUM_HARTS];
    logic        timer_int_reg [NUM_HARTS];
    logic [63:0] mtimecmp_reg  [NUM_HARTS];
    logic [63:0] mtime_reg;
    logic [15:0] pcnt_reg;
    logic        tick;
    logic        mtime_wr;

    // rd_chain[0] carries mtime, each hart ORs in its own word
    logic [31:0] rd_chain [NUM_HARTS+1];
    logic [31:0] rd_next;

    // Replace only the byte lanes enabled in we.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  we);
        logic [31:0] result;
        result = old_word;
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                result[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return result;
    endfunction

    // A request is taken only while no ack is outstanding, so a strobe held
    // through its ack cycle never commits twice.
    assign accept   = i_stb & ~ack_reg;
    assign is_write = |i_we;

    // Word-granular decode; the two byte-offset bits do not select anything.
    assign msip_hart        = i_addr[4:2];
    assign cmp_hart         = i_addr[5:3];
    assign hi_word          = i_addr[2];
    assign sel_msip         = (i_addr[15:5] == 11'd0) && ({1'b0, msip_hart} < HART_LIMIT);
    assign sel_cmp          = (i_addr[15:6] == 10'h100) && ({1'b0, cmp_hart} < HART_LIMIT);
    assign sel_mtime        = (i_addr[15:3] == 13'h17FF);
    assign unused_addr_bits = ^i_addr[1:0];

    assign tick     = (pcnt_reg == PCNT_LAST);
    assign mtime_wr = accept & is_write & sel_mtime;

    // Prescaler and mtime; a bus write wins over a tick and restarts the prescaler.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mtime_reg <= 64'd0;
            pcnt_reg  <= 16'd0;
        end else if (mtime_wr) begin
            pcnt_reg <= 16'd0;
            if (hi_word) begin
                mtime_reg[63:32] <= merge_lanes(mtime_reg[63:32], i_dat_w, i_we);
            end else begin
                mtime_reg[31:0]  <= merge_lanes(mtime_reg[31:0], i_dat_w, i_we);
            end
        end else if (tick) begin
            pcnt_reg  <= 16'd0;
            mtime_reg <= mtime_reg + 64'd1;
        end else begin
            pcnt_reg <= pcnt_reg + 16'd1;
        end
    end

    assign rd_chain[0] = sel_mtime ? (hi_word ? mtime_reg[63:32] : mtime_reg[31:0]) : 32'd0;

    generate
        for (genvar gi = 0; gi < NUM_HARTS; gi++) begin : g_hart
            logic [31:0] hart_word;

            // msip only has bit 0, written through byte lane 0.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    msip_reg[gi] <= 1'b0;
                end else if (accept && sel_msip && (msip_hart == 3'(gi)) && i_we[0]) begin
                    msip_reg[gi] <= i_dat_w[0];
                end
            end

            // mtimecmp words are written independently; no 64-bit atomicity.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    mtimecmp_reg[gi] <= MTIMECMP_RST;
                end else if (accept && is_write && sel_cmp && (cmp_hart == 3'(gi))) begin
                    if (hi_word) begin
                        mtimecmp_reg[gi][63:32] <= merge_lanes(mtimecmp_reg[gi][63:32], i_dat_w, i_we);
                    end else begin
                        mtimecmp_reg[gi][31:0]  <= merge_lanes(mtimecmp_reg[gi][31:0], i_dat_w, i_we);
                    end
                end
            end

            // Timer interrupt registers the compare of the current register values.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    timer_int_reg[gi] <= 1'b0;
                end else begin
                    timer_int_reg[gi] <= (mtime_reg >= mtimecmp_reg[gi]);
                end
            end

            assign hart_word =
                (sel_msip && (msip_hart == 3'(gi))) ? {31'd0, msip_reg[gi]} :
                (sel_cmp && (cmp_hart == 3'(gi)))   ? (hi_word ? mtimecmp_reg[gi][63:32]
                                                               : mtimecmp_reg[gi][31:0]) :
                                                      32'd0;
            assign rd_chain[gi+1]     = rd_chain[gi] | hart_word;
            assign o_timer_int[gi]    = timer_int_reg[gi];
            assign o_software_int[gi] = msip_reg[gi];
        end
    endgenerate

    assign rd_next = rd_chain[NUM_HARTS];

    // Bus response: one-cycle ack after acceptance, read data captured with it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ack_reg   <= 1'b0;
            dat_r_reg <= 32'd0;
        end else begin
            ack_reg <= accept;
            if (accept) begin
                dat_r_reg <= rd_next;
            end
        end
    end

    assign o_ack   = ack_reg;
    assign o_dat_r = dat_r_reg;

endmodule

// File: doc/clint_mp.md
Name: clint_mp

Overview:
- Multi-hart core-local interruptor; parametrised successor to the single-hart CLINT.
- Provides per-hart msip and mtimecmp registers, and one shared 64-bit mtime with a programmable prescaler.
- mtime is writable.
- Bus interface uses a registered one-wait-state strobe/ack.
- Sits at 0x02000000 on the system bus. Drives the timer and software interrupt lines into each core.

Parameters:
- NUM_HARTS, 2: number of harts; legal range 1..8.
- DIV, 1: mtime increments once every DIV i_clk cycles; legal range 1..65535.
- MTIMECMP_RST, 64'h7fffffff_ffffffff: reset value of every mtimecmp.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset; synchronous, active-high.
- i_addr  in  16  byte offset within the CLINT window.
- i_we  in  4  byte-lane write enables; all zero means read.
- i_dat_w  in  32  write data.
- o_dat_r  out  32  registered read data.
- i_stb  in  1  request strobe; master holds it high until o_ack.
- o_ack  out  1  one-cycle acknowledge.
- o_timer_int  out  NUM_HARTS  per-hart machine timer interrupt, registered.
- o_software_int  out  NUM_HARTS  per-hart msip bit.

Behaviour:
- Address map (h = hart index):
  - msip[h] at 0x0000+4h: bit 0 only; bits 31:1 read 0.
  - mtimecmp[h] low word at 0x4000+8h; high word at 0x4004+8h.
  - mtime low word at 0xBFF8; high word at 0xBFFC.
- Offsets for h >= NUM_HARTS, and all other offsets, are unmapped: reads return 0, writes are ignored, o_ack is still given.
- Handshake:
  - A request is accepted in the cycle where i_stb=1 and o_ack=0.
  - o_ack=1 in the following cycle only, and o_ack is never high two consecutive cycles.
  - o_dat_r is valid in the o_ack cycle. It holds its value otherwise; reset value is 0.
  - The write side effect is committed at the acceptance edge. A held strobe never causes a second write.
- Writes use byte lanes per i_we. msip takes i_we[0] and i_dat_w[0] only.
- Prescaler:
  - 16-bit counter pcnt runs 0..DIV-1 and wraps.
  - tick = (pcnt==DIV-1); on tick, mtime <= mtime+1.
  - With DIV=1, mtime increments every cycle.
  - mtime wraps 0xFFFFFFFF_FFFFFFFF -> 0 with no flag.
- mtime write:
  - The written lanes replace the corresponding bytes of the current mtime value.
  - A write has priority over a tick in the same cycle: that increment is lost.
  - pcnt restarts at 0 on any mtime write.
  - Carry between the words is the software's problem: no atomic 64-bit write.
- Timer interrupt: at every edge, o_timer_int[h] <= (mtime >= mtimecmp[h]), unsigned 64-bit compare of the current register values.
  - Consequence: the interrupt follows a register change with exactly 1 cycle of latency.
  - Writing mtimecmp to a value above mtime clears the bit 1 cycle after the write commits.
- o_software_int[h] = msip[h], directly from the register.
- Reset state:
  - msip=0, mtimecmp=MTIMECMP_RST, mtime=0, pcnt=0.
  - o_ack=0, o_dat_r=0, o_timer_int=0.
- Reset mid-request: any pending ack is dropped and nothing is committed. The master must re-issue.
- Simultaneous writes to different registers cannot occur (single bus port).

Test Plan:
- Reset, DIV=1: read 0xBFF8 twice, 10 cycles apart -> second value = first + 10. Both o_timer_int bits stay 0; o_ack is exactly one cycle per request.
- DIV=4: write mtime low = 0x100 with i_we=4'hF, then read 0xBFF8 after 8 cycles -> 0x102. No increment occurs in the write cycle.
- Hart 1: write 0x4008=0x20 and 0x400C=0, with mtime=0x10 and DIV=1 -> o_timer_int=2'b10 from cycle mtime=0x20, +1 lag. Hart 0 bit stays 0. Writing 0x400C=1 clears bit 1 one cycle after commit.
- Write 0x0004=0x3, then 0x0000=0x1 -> o_software_int goes 2'b10, then 2'b11. Read 0x0004 -> 0x00000001. Write 0x0004=0 -> 2'b01.
- i_stb held 5 cycles on a write to 0x0000=1 followed by a read -> single o_ack pulse, single commit. Unmapped 0x0010 (NUM_HARTS=2) reads 0 and is acked.
- Wrap: write mtime=0xFFFFFFFF_FFFFFFFE, DIV=1 -> reads 0 two cycles later. With mtimecmp[0]=0xFFFFFFFF_FFFFFFFF, the interrupt asserts, then drops after the wrap, 1 cycle lag each.
